sys_array_result_streamer: RTL and testbench

//  Drain side of sys_array_fetcher_split: on the rising edge of the fetcher's ready,

---
 rtl/sys_array_result_streamer.sv | 110 +++++++++++
 tb/tb_sys_array_result_streamer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_result_streamer.sv
// Drains a snapshot of the systolic-array result matrix row-major over a valid/ready stream.
// A rising edge on comp_ready captures the matrix; the fetcher is free as soon as it is captured.
module sys_array_result_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_A_W  = 4,
    parameter int unsigned ARRAY_W_L  = 8,
    localparam int unsigned EW = 2 * DATA_WIDTH,
    localparam int unsigned RW = ($clog2(ARRAY_A_W) > 0) ? $clog2(ARRAY_A_W) : 1,
    localparam int unsigned CW = ($clog2(ARRAY_W_L) > 0) ? $clog2(ARRAY_W_L) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         comp_ready,
    input  logic [ARRAY_A_W-1:0][ARRAY_W_L-1:0][EW-1:0]  out_data,
    output logic                                         s_valid,
    input  logic                                         s_ready,
    output logic [EW-1:0]                                s_data,
    output logic [RW-1:0]                                s_row,
    output logic [CW-1:0]                                s_col,
    output logic                                         s_last,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overrun
);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e  state_q, state_d;
    logic    rdy_q;
    logic    capture;
    logic    load;
    logic    last_elem;
    logic    overrun_q, overrun_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [ARRAY_A_W-1:0][ARRAY_W_L-1:0][EW-1:0] snap_q;

    // rdy_q resets high so a comp_ready already asserted at release is not an edge
    assign capture   = comp_ready & ~rdy_q;
    assign last_elem = (row_q == RW'(ARRAY_A_W - 1)) && (col_q == CW'(ARRAY_W_L - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rdy_q     <= 1'b1;
            overrun_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= comp_ready;
            overrun_q <= overrun_d;
            row_q     <= row_d;
            col_q     <= col_d;
            if (load) begin
                snap_q <= out_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        load      = 1'b0;
        overrun_d = overrun_q | (capture & (state_q != StIdle));
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    load    = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                // s_valid is always high here, so s_ready alone marks a beat
                if (s_ready) begin
                    if (last_elem) begin
                        state_d = StDone;
                    end else if (col_q == CW'(ARRAY_W_L - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        s_valid = (state_q == StStream);
        s_data  = s_valid ? snap_q[row_q][col_q] : '0;
        s_row   = s_valid ? row_q : '0;
        s_col   = s_valid ? col_q : '0;
        s_last  = s_valid & last_elem;
        busy    = s_valid;
        done    = (state_q == StDone);
        overrun = overrun_q;
    end

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Scoreboard bench for sys_array_result_streamer: expected beats are queued when a matrix is
// captured and a negedge monitor pops and compares every accepted beat.
module tb_sys_array_result_streamer;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         comp_ready;
    logic [3:0][7:0][15:0]        out_data;
    logic                         s_valid;
    logic                         s_ready;
    logic [15:0]                  s_data;
    logic [1:0]                   s_row;
    logic [2:0]                   s_col;
    logic                         s_last;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    int applied = 0;
    int miscompares = 0;
    int beats = 0;
    logic [21:0] exp_q[$];

    logic        hold_pending = 1'b0;
    logic [21:0] held;

    sys_array_result_streamer #(
        .DATA_WIDTH(8),
        .ARRAY_A_W (4),
        .ARRAY_W_L (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .comp_ready(comp_ready),
        .out_data  (out_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_row     (s_row),
        .s_col     (s_col),
        .s_last    (s_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares accepted beats against the queue and checks stalled beats stay put.
    always @(negedge clk) begin
        logic [21:0] cur;
        logic [21:0] exp;
        cur = {s_last, s_row, s_col, s_data};
        if (reset_n && hold_pending) begin
            check("stall hold", {s_valid, cur}, {1'b1, held});
        end
        hold_pending = 1'b0;
        if (reset_n && s_valid) begin
            if (s_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected beat", {1'b1, cur}, 32'h0);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat {last,row,col,data}", cur, exp);
                end
            end else begin
                hold_pending = 1'b1;
                held = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                out_data[r][c] = 16'(256 * r + c);
    endtask

    task automatic push_matrix();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                exp_q.push_back({(r == 3 && c == 7), 2'(r), 3'(c), out_data[r][c]});
    endtask

    // Produces a fresh comp_ready edge; capture happens at the next posedge.
    task automatic start_stream();
        comp_ready = 1'b0;
        tick();
        push_matrix();
        comp_ready = 1'b1;
    endtask

    task automatic run_until_done(input int limit, input bit alt, output int k);
        k = 0;
        while (!done && k < limit) begin
            if (alt) s_ready = ~s_ready;
            tick();
            k++;
        end
        if (!done) check("done timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats < target && n < 200) begin
            tick();
            n++;
        end
        check("beat count reached", beats, target);
    endtask

    initial begin
        int k;
        int base;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        reset_n    = 1'b0;
        comp_ready = 1'b1;
        s_ready    = 1'b1;
        set_pattern();

        // 1: reset values, then no stream without a fresh edge
        #3;
        check("reset outputs",
              {s_valid, s_data, s_row, s_col, s_last, busy, done, overrun}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no stream after release", {s_valid, busy}, 32'h0);

        // 2: full-rate stream, done at capture+33
        start_stream();
        run_until_done(100, 1'b0, k);
        check("capture-to-done cycles", k, 33);
        check("busy low at done", busy, 0);
        check("queue drained", exp_q.size(), 0);
        tick();
        check("done one cycle", done, 0);

        // 3: alternating s_ready
        s_ready = 1'b1;
        start_stream();
        run_until_done(100, 1'b1, k);
        check("alt queue drained", exp_q.size(), 0);
        check("alt cycles ~64", (k >= 60 && k <= 70), 1);
        s_ready = 1'b1;
        tick();

        // 4a: snapshot isolates from later out_data changes
        start_stream();
        tick();
        out_data = {32{16'hFFFF}};
        run_until_done(100, 1'b0, k);
        check("isolated capture-to-done", k, 32);
        check("isolated queue drained", exp_q.size(), 0);

        // 4b: negative element passes bit-exact
        set_pattern();
        out_data[2][5] = 16'h8001;
        start_stream();
        run_until_done(100, 1'b0, k);
        check("negative queue drained", exp_q.size(), 0);
        check("no overrun yet", overrun, 0);

        // 5: fresh edge mid-stream sets sticky overrun, stream unchanged
        set_pattern();
        base = beats;
        start_stream();
        wait_beats(base + 10);
        comp_ready = 1'b0;
        tick();
        comp_ready = 1'b1;
        tick();
        check("overrun set", overrun, 1);
        run_until_done(100, 1'b0, k);
        check("overrun queue drained", exp_q.size(), 0);
        for (int i = 0; i < 40; i++) tick();
        check("no second stream", {s_valid, busy}, 32'h0);
        check("overrun sticky", overrun, 1);
        check("overrun run beats", beats - base, 32);

        // 6: reset mid-stream drops outputs immediately, then a fresh stream restarts at (0,0)
        base = beats;
        start_stream();
        wait_beats(base + 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("async drop s_valid/busy", {s_valid, busy, s_last}, 32'h0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("overrun cleared by reset", overrun, 0);
        check("no stream after mid reset", s_valid, 0);
        start_stream();
        run_until_done(100, 1'b0, k);
        check("restart capture-to-done", k, 33);
        check("restart queue drained", exp_q.size(), 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
